// File: rtl/rr_slot_arbiter_pkg.sv
// rtl/rr_slot_arbiter_pkg.sv - shared types, widths and pointer helper for the slot arbiter
package rr_slot_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int HOLD_CNT_W = 16;

    // Modulo advance of a requester index; wraps from num-1 back to 0.
    function automatic int ptr_inc(input int ptr, input int num);
        return (ptr >= num - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate-and-find-first over the eligible vector, starting at start
module rr_priority_pick
    import rr_slot_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   start,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    int                   pos;

    // Bit i of rotated is requester (start + i) mod NUM_REQ.
    assign doubled = {eligible, eligible} >> start;
    assign rotated = doubled[NUM_REQ-1:0];

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = int'(start);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                idx   = PTR_W'(pos);
            end
            pos = ptr_inc(pos, NUM_REQ);
        end
    end

endmodule

// File: rtl/rr_slot_arbiter.sv
// rtl/rr_slot_arbiter.sv - round-robin arbiter with per-grant hold limit and one-hot select
module rr_slot_arbiter
    import rr_slot_arbiter_pkg::*;
#(
    parameter int  NUM_REQ  = 5,
    parameter int  MAX_HOLD = 8,
    localparam int PTR_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] enable_mask,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [PTR_W-1:0]   gnt_id,
    output logic               preempt,
    output logic [PTR_W-1:0]   next_ptr
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD);

    arb_state_t            state;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  pick_found;
    logic [PTR_W-1:0]      pick_idx;
    logic                  owner_active;
    logic [PTR_W-1:0]      after_owner;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .eligible (req & enable_mask),
        .start    (next_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign owner_active = req[gnt_id] & enable_mask[gnt_id];
    assign after_owner  = PTR_W'(ptr_inc(int'(gnt_id), NUM_REQ));
    assign gnt_valid    = |gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            preempt  <= 1'b0;
            next_ptr <= '0;
            hold_cnt <= '0;
        end else begin
            preempt <= 1'b0;
            if (state == IDLE) begin
                if (pick_found) begin
                    state    <= GRANT;
                    gnt      <= NUM_REQ'(1) << pick_idx;
                    gnt_id   <= pick_idx;
                    hold_cnt <= HOLD_CNT_W'(1);
                end
            end else begin
                // Owner dropping out wins over the hold limit, so preempt only marks a forced release.
                if (!owner_active) begin
                    state    <= IDLE;
                    gnt      <= '0;
                    hold_cnt <= '0;
                    next_ptr <= after_owner;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT) begin
                    state    <= IDLE;
                    gnt      <= '0;
                    hold_cnt <= '0;
                    next_ptr <= after_owner;
                    preempt  <= 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// tb/tb_rr_slot_arbiter.sv - randomized and directed bench with behavioural model for two hold limits
module tb_rr_slot_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] enable_mask;

    logic [N-1:0] gnt_a, gnt_b;
    logic         gnt_valid_a, gnt_valid_b;
    logic [2:0]   gnt_id_a, gnt_id_b;
    logic         preempt_a, preempt_b;
    logic [2:0]   next_ptr_a, next_ptr_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rr_slot_arbiter #(.NUM_REQ(N), .MAX_HOLD(8)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .enable_mask (enable_mask),
        .gnt         (gnt_a),
        .gnt_valid   (gnt_valid_a),
        .gnt_id      (gnt_id_a),
        .preempt     (preempt_a),
        .next_ptr    (next_ptr_a)
    );

    rr_slot_arbiter #(.NUM_REQ(N), .MAX_HOLD(4)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .enable_mask (enable_mask),
        .gnt         (gnt_b),
        .gnt_valid   (gnt_valid_b),
        .gnt_id      (gnt_id_b),
        .preempt     (preempt_b),
        .next_ptr    (next_ptr_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: owner index (-1 when idle), cycles held, priority pointer, last id, preempt pulse.
    int m_owner[2] = '{-1, -1};
    int m_held[2]  = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_id[2]    = '{0, 0};
    int m_pre[2]   = '{0, 0};

    function automatic int hold_limit(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        logic [N-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic int model_pick(input int ptr, input logic [N-1:0] elig);
        for (int o = 0; o < N; o++)
            if (bit_of(elig, (ptr + o) % N)) return (ptr + o) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                m_owner[u] <= -1;
                m_held[u]  <= 0;
                m_ptr[u]   <= 0;
                m_id[u]    <= 0;
                m_pre[u]   <= 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_pre[u] <= 0;
                if (m_owner[u] < 0) begin
                    if (model_pick(m_ptr[u], req & enable_mask) >= 0) begin
                        m_owner[u] <= model_pick(m_ptr[u], req & enable_mask);
                        m_id[u]    <= model_pick(m_ptr[u], req & enable_mask);
                        m_held[u]  <= 1;
                    end
                end else if (!bit_of(req & enable_mask, m_owner[u])) begin
                    m_owner[u] <= -1;
                    m_ptr[u]   <= (m_owner[u] + 1) % N;
                end else if (m_held[u] == hold_limit(u)) begin
                    m_owner[u] <= -1;
                    m_ptr[u]   <= (m_owner[u] + 1) % N;
                    m_pre[u]   <= 1;
                end else begin
                    m_held[u] <= m_held[u] + 1;
                end
            end
        end
    end

    task automatic compare_unit(input int u, input logic [N-1:0] g, input logic v,
                                input logic [2:0] id, input logic p, input logic [2:0] np);
        string tag;
        tag = (u == 0) ? "h8" : "h4";
        check({tag, ".gnt"},       int'(g),  (m_owner[u] < 0) ? 0 : (1 << m_owner[u]));
        check({tag, ".gnt_valid"}, int'(v),  (m_owner[u] < 0) ? 0 : 1);
        check({tag, ".gnt_id"},    int'(id), m_id[u]);
        check({tag, ".preempt"},   int'(p),  m_pre[u]);
        check({tag, ".next_ptr"},  int'(np), m_ptr[u]);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            compare_unit(0, gnt_a, gnt_valid_a, gnt_id_a, preempt_a, next_ptr_a);
            compare_unit(1, gnt_b, gnt_valid_b, gnt_id_b, preempt_b, next_ptr_b);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int run_a, run_b, max_a, max_b, pre_a, pre_b;
        int order[7];
        int gaps[6];
        int seq[4];
        int runs[4];
        int n_gr, n_run, gap, hcnt, prev_id;
        bit prev_v, seen0;
        int exp_order[7] = '{0, 1, 2, 3, 4, 0, 1};

        reset       = 1'b0;
        req         = '0;
        enable_mask = '1;
        repeat (2) @(negedge clk);
        check("rst.gnt",       int'(gnt_a),       0);
        check("rst.gnt_valid", int'(gnt_valid_a), 0);
        check("rst.gnt_id",    int'(gnt_id_a),    0);
        check("rst.preempt",   int'(preempt_a),   0);
        check("rst.next_ptr",  int'(next_ptr_a),  0);
        reset = 1'b1;

        // single requester, then asynchronous reset in the middle of a grant
        req = 5'b00100;
        @(negedge clk);
        check("single.gnt",    int'(gnt_a),    4);
        check("single.gnt_id", int'(gnt_id_a), 2);
        req = '0;
        @(negedge clk);
        check("single.drop_gnt", int'(gnt_a),      0);
        check("single.next_ptr", int'(next_ptr_a), 3);
        req = 5'b00100;
        @(negedge clk);
        check("midrst.pre_gnt", int'(gnt_b), 4);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.gnt_a",     int'(gnt_a),       0);
        check("midrst.gnt_b",     int'(gnt_b),       0);
        check("midrst.gnt_valid", int'(gnt_valid_a), 0);
        check("midrst.gnt_id",    int'(gnt_id_a),    0);
        check("midrst.next_ptr",  int'(next_ptr_a),  0);
        @(negedge clk);
        req   = '0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst.idle_gnt", int'(gnt_a), 0);
        end

        // hold limit: one requester held high for 30 cycles
        do_reset();
        req = 5'b00010;
        run_a = 0; run_b = 0; max_a = 0; max_b = 0; pre_a = 0; pre_b = 0;
        repeat (30) begin
            @(negedge clk);
            if (gnt_a[1]) run_a++;
            else begin if (run_a > max_a) max_a = run_a; run_a = 0; end
            if (gnt_b[1]) run_b++;
            else begin if (run_b > max_b) max_b = run_b; run_b = 0; end
            pre_a += int'(preempt_a);
            pre_b += int'(preempt_b);
        end
        if (run_a > max_a) max_a = run_a;
        if (run_b > max_b) max_b = run_b;
        check("hold.h8_run",      max_a, 8);
        check("hold.h4_run",      max_b, 4);
        check("hold.h8_preempts", pre_a, 3);
        check("hold.h4_preempts", pre_b, 6);

        // preempt fairness: two constant requesters alternate under the hold limit
        do_reset();
        req = 5'b01010;
        n_gr = 0; n_run = 0; run_b = 0; prev_v = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (gnt_valid_b && !prev_v && n_gr < 4) begin
                seq[n_gr] = int'(gnt_id_b);
                n_gr++;
            end
            if (gnt_valid_b) run_b++;
            else if (run_b > 0) begin
                if (n_run < 4) runs[n_run] = run_b;
                n_run++;
                run_b = 0;
            end
            prev_v = gnt_valid_b;
        end
        check("fair.grants", n_gr, 4);
        check("fair.runs",   n_run, 4);
        for (int i = 0; i < 4 && i < n_gr; i++) check("fair.id", seq[i], (i % 2 == 0) ? 1 : 3);
        for (int i = 0; i < 4 && i < n_run; i++) check("fair.len", runs[i], 4);

        // wrap fairness: all request, each drops req two cycles into its grant
        do_reset();
        req = '1;
        n_gr = 0; gap = 0; hcnt = 0; prev_v = 1'b0; prev_id = 0;
        for (int c = 0; c < 60 && n_gr < 7; c++) begin
            @(negedge clk);
            req = '1;
            if (gnt_valid_a) begin
                if (!prev_v) begin
                    order[n_gr] = int'(gnt_id_a);
                    if (n_gr > 0) gaps[n_gr-1] = gap;
                    n_gr++;
                    hcnt = 0;
                    gap  = 0;
                end
                hcnt++;
                if (hcnt == 2) req[gnt_id_a] = 1'b0;
            end else begin
                gap++;
                if (prev_v && prev_id == 4) check("wrap.ptr_wrap", int'(next_ptr_a), 0);
            end
            prev_v  = gnt_valid_a;
            prev_id = int'(gnt_id_a);
        end
        check("wrap.grants", n_gr, 7);
        for (int i = 0; i < 7 && i < n_gr; i++) check("wrap.order", order[i], exp_order[i]);
        for (int i = 0; i < 6 && i < n_gr - 1; i++) check("wrap.bubble", gaps[i], 1);

        // mask: clearing the owner's enable releases without preempt; masked requester never served
        do_reset();
        enable_mask = '1;
        req = 5'b00001;
        @(negedge clk);
        check("mask.gnt0", int'(gnt_a), 1);
        enable_mask = 5'b11110;
        @(negedge clk);
        check("mask.release", int'(gnt_a),     0);
        check("mask.preempt", int'(preempt_a), 0);
        req   = '1;
        seen0 = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen0 |= gnt_a[0] | gnt_b[0];
        end
        check("mask.never0", int'(seen0), 0);
        enable_mask = '1;
        req = '0;

        // randomized traffic with slowly changing requests and masks
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                if ($urandom_range(63) == 0) enable_mask[i] = ~enable_mask[i];
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters (default 5).
- A modulo-NUM_REQ priority pointer rotates 0..NUM_REQ-1 and wraps to 0, so every enabled requester is served fairly.
- A per-grant hold limit forces release, so no requester can starve the others.
- The arbiter sits between the requester front-ends and the shared unit, and supplies the one-hot select for that unit.

Parameters:
- NUM_REQ, 5, number of requesters; must be >= 2.
- MAX_HOLD, 8, maximum consecutive grant cycles per grant; 0 means unlimited.
- PTR_W, $clog2(NUM_REQ), width of the pointer and gnt_id; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request bits; a requester holds its bit high for the whole time it uses the resource.
- enable_mask  input  NUM_REQ  configuration; a 0 bit makes that requester ineligible.
- gnt  output  NUM_REQ  one-hot grant; registered.
- gnt_valid  output  1  high while any grant is active; equals |gnt.
- gnt_id  output  PTR_W  index of the granted requester; holds its last value when gnt_valid=0.
- preempt  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.
- next_ptr  output  PTR_W  current highest-priority index; for debug and coverage.

Behaviour:
- Reset (reset=0, asynchronous, effective immediately even mid-grant):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0, next_ptr=0.
  - hold_cnt=0, state=IDLE.
- State machine has two states: IDLE and GRANT.
- IDLE:
  - Eligible set is req & enable_mask.
  - Search starts at next_ptr in rotated order: next_ptr, next_ptr+1, ... wrapping at NUM_REQ-1 to 0.
  - If the first eligible index k is found, at the next edge: state=GRANT, gnt=onehot(k), gnt_id=k, hold_cnt=1.
  - Latency: eligible req sampled at edge t gives gnt high after edge t.
  - If nothing is eligible, stay in IDLE; all outputs hold.
- GRANT (granted id g), evaluated every edge in this priority order:
  - 1. req[g]=0 or enable_mask[g]=0: release, no preempt.
  - 2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD: release, preempt=1 for exactly one cycle, registered together with gnt dropping.
  - 3. Otherwise: hold_cnt increments (saturating at MAX_HOLD; with MAX_HOLD=0 a 16-bit counter saturates at all-ones); gnt unchanged.
- On release, at the same edge:
  - gnt=0, state=IDLE.
  - next_ptr = (g==NUM_REQ-1) ? 0 : g+1. The pointer never equals or exceeds NUM_REQ.
- Exactly one IDLE bubble cycle occurs between consecutive grants. There are no back-to-back grants.
- With MAX_HOLD=N, a continuously requesting owner holds gnt for exactly N cycles.
- A preempted requester that keeps req high competes normally. It has lowest priority on the next arbitration.
- Requests from other requesters during GRANT have no effect until release.
- enable_mask and req changes take effect at the next sampling edge. There is no synchronisation inside the block; inputs are synchronous to clk.
- gnt is at most one-hot at all times. gnt_valid=0 implies gnt==0.

Decomposition:
- Package rr_slot_arbiter_pkg holds:
  - state typedef (IDLE, GRANT);
  - HOLD_CNT_W=16;
  - helper function ptr_inc(ptr, num) implementing the modulo wrap.
- One sub-module, rr_priority_pick:
  - combinational rotate-and-find-first;
  - inputs: eligible vector and start pointer;
  - outputs: found flag and index.
  - It is unit-testable in isolation.

Test Plan:
- Reset: drive reset=0 mid-grant (gnt=0b00100) -> all outputs 0 immediately without a clock edge; after release, req=0 gives no grant.
- Single requester: req=0b00100, mask=all 1s -> gnt=0b00100 and gnt_id=2 one edge later; drop req -> gnt=0 next edge, next_ptr=3.
- Wrap fairness: all 5 request, each drops req 2 cycles after its grant -> grant order 0,1,2,3,4,0,1 with one bubble between grants; next_ptr wraps 4->0.
- Hold limit: MAX_HOLD=8, only req[1] held high for 30 cycles -> gnt[1] high exactly 8 cycles, preempt pulses once, 1-cycle gap, then re-granted; repeats.
- Preempt fairness: req[1] and req[3] held high constantly, MAX_HOLD=4 -> grants alternate 1,3,1,3, each 4 cycles long.
- Mask: req[0] granted, then clear enable_mask[0] -> gnt drops next edge with preempt=0; a masked requester with req high is never granted.
